// File: rtl/frame_mem_arbiter.sv
// Two-requester burst arbiter for the frame memory command port.
// Display reads win by default; a starvation counter forces writes through.
module frame_mem_arbiter #(
  parameter int ADDR_WIDTH     = 22,
  parameter int BURST_LEN      = 16,
  parameter int BEAT_CNT_WIDTH = 5,
  parameter int WR_MAX_WAIT    = 64,
  parameter int WAIT_CNT_WIDTH = 7
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_gnt,
  output logic                  rd_done,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  wr_gnt,
  output logic                  wr_done,
  output logic                  mem_cmd_valid,
  input  logic                  mem_cmd_ready,
  output logic                  mem_cmd_we,
  output logic [ADDR_WIDTH-1:0] mem_cmd_addr,
  input  logic                  mem_beat,
  output logic                  busy,
  output logic                  owner
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    BURST,
    DONE
  } state_e;

  localparam logic [BEAT_CNT_WIDTH-1:0] LAST_BEAT =
    BEAT_CNT_WIDTH'(BURST_LEN - 1);
  localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_MAX =
    WAIT_CNT_WIDTH'(WR_MAX_WAIT);

  state_e                    state_q, state_d;
  logic [BEAT_CNT_WIDTH-1:0] beat_q, beat_d;
  logic [WAIT_CNT_WIDTH-1:0] wait_q, wait_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic                      rd_gnt_q, rd_gnt_d;
  logic                      wr_gnt_q, wr_gnt_d;
  logic                      we_q, we_d;
  logic                      owner_q, owner_d;
  logic                      grant_rd, grant_wr;
  logic                      wr_starved;

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    wait_d     = wait_q;
    addr_d     = addr_q;
    rd_gnt_d   = 1'b0;
    wr_gnt_d   = 1'b0;
    we_d       = we_q;
    owner_d    = owner_q;
    grant_rd   = 1'b0;
    grant_wr   = 1'b0;
    wr_starved = (wait_q >= WAIT_MAX);

    unique case (state_q)
      IDLE: begin
        if (wr_req && wr_starved) begin
          grant_wr = 1'b1;
        end else if (rd_req) begin
          grant_rd = 1'b1;
        end else if (wr_req) begin
          grant_wr = 1'b1;
        end
        if (grant_rd || grant_wr) begin
          state_d  = ISSUE;
          rd_gnt_d = grant_rd;
          wr_gnt_d = grant_wr;
          we_d     = grant_wr;
          owner_d  = grant_wr;
          addr_d   = grant_wr ? wr_addr : rd_addr;
        end
      end
      ISSUE: begin
        if (mem_cmd_ready) begin
          beat_d  = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        if (mem_beat) begin
          beat_d = beat_q + BEAT_CNT_WIDTH'(1);
          if (beat_q == LAST_BEAT) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // The gnt cycle still sees wr_req high, so it must not count as waiting.
    if (!wr_req || grant_wr || wr_gnt_q) begin
      wait_d = '0;
    end else if (!wr_starved) begin
      wait_d = wait_q + WAIT_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      wait_q   <= '0;
      addr_q   <= '0;
      rd_gnt_q <= 1'b0;
      wr_gnt_q <= 1'b0;
      we_q     <= 1'b0;
      owner_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      wait_q   <= wait_d;
      addr_q   <= addr_d;
      rd_gnt_q <= rd_gnt_d;
      wr_gnt_q <= wr_gnt_d;
      we_q     <= we_d;
      owner_q  <= owner_d;
    end
  end

  assign rd_gnt        = rd_gnt_q;
  assign wr_gnt        = wr_gnt_q;
  assign mem_cmd_valid = (state_q == ISSUE);
  assign mem_cmd_we    = we_q;
  assign mem_cmd_addr  = addr_q;
  assign rd_done       = (state_q == DONE) && !owner_q;
  assign wr_done       = (state_q == DONE) && owner_q;
  assign busy          = (state_q != IDLE);
  assign owner         = owner_q;

endmodule

// File: tb/tb_frame_mem_arbiter.sv
// Directed bench for frame_mem_arbiter: arbitration table plus
// hand-written multi-cycle sequences.
module tb_frame_mem_arbiter;

  localparam int AW = 22;

  logic          clock;
  logic          reset;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_gnt;
  logic          rd_done;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic          wr_gnt;
  logic          wr_done;
  logic          mem_cmd_valid;
  logic          mem_cmd_ready;
  logic          mem_cmd_we;
  logic [AW-1:0] mem_cmd_addr;
  logic          mem_beat;
  logic          busy;
  logic          owner;

  int n_cmp = 0;
  int n_err = 0;

  frame_mem_arbiter dut (
    .clock         (clock),
    .reset         (reset),
    .rd_req        (rd_req),
    .rd_addr       (rd_addr),
    .rd_gnt        (rd_gnt),
    .rd_done       (rd_done),
    .wr_req        (wr_req),
    .wr_addr       (wr_addr),
    .wr_gnt        (wr_gnt),
    .wr_done       (wr_done),
    .mem_cmd_valid (mem_cmd_valid),
    .mem_cmd_ready (mem_cmd_ready),
    .mem_cmd_we    (mem_cmd_we),
    .mem_cmd_addr  (mem_cmd_addr),
    .mem_beat      (mem_beat),
    .busy          (busy),
    .owner         (owner)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic          rd;
    logic          wr;
    logic [AW-1:0] ra;
    logic [AW-1:0] wa;
    logic          e_rg;
    logic          e_wg;
    logic [AW-1:0] e_addr;
    logic          e_owner;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (n < 60) begin
      step();
      n++;
      if (rd_done || wr_done) return;
    end
    n = 99;
  endtask

  int n;
  int reads;
  int cnt;
  int bad;
  bit wgnt;
  bit seen;
  logic pat;

  initial begin
    reset = 1'b1;
    rd_req = 1'b0;
    wr_req = 1'b0;
    rd_addr = '0;
    wr_addr = '0;
    mem_cmd_ready = 1'b1;
    mem_beat = 1'b1;

    vecs[0] = '{1'b1, 1'b0, 22'h000100, 22'h000000,
                1'b1, 1'b0, 22'h000100, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 22'h000000, 22'h3FFFFF,
                1'b0, 1'b1, 22'h3FFFFF, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 22'h2AAAAA, 22'h155555,
                1'b1, 1'b0, 22'h2AAAAA, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 22'h000000, 22'h000000,
                1'b0, 1'b0, 22'h000000, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 22'h000000, 22'h000001,
                1'b0, 1'b1, 22'h000001, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 22'h000000, 22'h000000,
                1'b0, 1'b0, 22'h000000, 1'b1};

    // Reset state
    step();
    step();
    reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_valid", mem_cmd_valid, 0);
    chk("rst_we", mem_cmd_we, 0);
    chk("rst_addr", mem_cmd_addr, 0);
    chk("rst_owner", owner, 0);
    chk("rst_pulses", {rd_gnt, wr_gnt, rd_done, wr_done}, 0);

    // Test 1: single read burst
    rd_req = 1'b1;
    rd_addr = 22'h000100;
    step();
    rd_req = 1'b0;
    chk("t1_rd_gnt", rd_gnt, 1);
    chk("t1_valid", mem_cmd_valid, 1);
    chk("t1_we", mem_cmd_we, 0);
    chk("t1_addr", mem_cmd_addr, 22'h000100);
    chk("t1_busy", busy, 1);
    step();
    chk("t1_valid_drop", mem_cmd_valid, 0);
    chk("t1_gnt_drop", rd_gnt, 0);
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (rd_done || !busy) bad++;
    end
    chk("t1_early_done", bad, 0);
    step();
    chk("t1_rd_done", rd_done, 1);
    chk("t1_busy_done", busy, 1);
    step();
    chk("t1_idle_busy", busy, 0);
    chk("t1_idle_done", rd_done, 0);

    // Arbitration table
    for (int v = 0; v < 6; v++) begin
      rd_req = vecs[v].rd;
      wr_req = vecs[v].wr;
      rd_addr = vecs[v].ra;
      wr_addr = vecs[v].wa;
      step();
      rd_req = 1'b0;
      wr_req = 1'b0;
      chk($sformatf("v%0d_rd_gnt", v), rd_gnt, vecs[v].e_rg);
      chk($sformatf("v%0d_wr_gnt", v), wr_gnt, vecs[v].e_wg);
      chk($sformatf("v%0d_owner", v), owner, vecs[v].e_owner);
      chk($sformatf("v%0d_valid", v), mem_cmd_valid,
          vecs[v].e_rg | vecs[v].e_wg);
      if (vecs[v].e_rg || vecs[v].e_wg) begin
        chk($sformatf("v%0d_we", v), mem_cmd_we, vecs[v].e_wg);
        chk($sformatf("v%0d_addr", v), mem_cmd_addr, vecs[v].e_addr);
        wait_done(n);
        chk($sformatf("v%0d_len", v), n, 17);
        chk($sformatf("v%0d_done", v), {rd_done, wr_done},
            {vecs[v].e_rg, vecs[v].e_wg});
        step();
      end else begin
        chk($sformatf("v%0d_busy", v), busy, 0);
      end
    end

    // Test 2: simultaneous requests, read first then write
    rd_req = 1'b1;
    wr_req = 1'b1;
    rd_addr = 22'h000010;
    wr_addr = 22'h000020;
    step();
    rd_req = 1'b0;
    chk("t2_rd_first", {rd_gnt, wr_gnt}, 2'b10);
    wait_done(n);
    chk("t2_rd_len", n, 17);
    chk("t2_rd_done", rd_done, 1);
    step();
    chk("t2_gap_idle", {busy, wr_gnt}, 0);
    step();
    wr_req = 1'b0;
    chk("t2_wr_gnt", wr_gnt, 1);
    chk("t2_wr_addr", mem_cmd_addr, 22'h000020);
    chk("t2_wr_owner", owner, 1);
    wait_done(n);
    chk("t2_wr_len", n, 17);
    chk("t2_wr_done", wr_done, 1);
    step();

    // Test 3: reads back-to-back, write forced through by starvation
    rd_req = 1'b1;
    wr_req = 1'b1;
    reads = 0;
    wgnt = 1'b0;
    for (int i = 0; i < 400 && !wgnt; i++) begin
      step();
      if (rd_gnt) reads++;
      if (wr_gnt) wgnt = 1'b1;
    end
    wr_req = 1'b0;
    chk("t3_wr_gnt_seen", wgnt, 1);
    chk("t3_reads_before", reads, 4);
    chk("t3_owner", owner, 1);
    wait_done(n);
    chk("t3_wr_len", n, 17);
    chk("t3_wr_done", wr_done, 1);
    wr_req = 1'b1;
    step();
    step();
    chk("t3_read_resumes", {rd_gnt, wr_gnt}, 2'b10);
    rd_req = 1'b0;
    wr_req = 1'b0;
    wait_done(n);
    step();

    // Test 4: command stall while ready is low
    mem_cmd_ready = 1'b0;
    wr_req = 1'b1;
    wr_addr = 22'h123456;
    step();
    wr_req = 1'b0;
    chk("t4_wr_gnt", wr_gnt, 1);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (!(mem_cmd_valid && mem_cmd_we && mem_cmd_addr == 22'h123456))
        bad++;
      if (i < 9) step();
    end
    chk("t4_stable", bad, 0);
    mem_cmd_ready = 1'b1;
    step();
    chk("t4_valid_drop", mem_cmd_valid, 0);
    wait_done(n);
    chk("t4_beats", n, 16);
    chk("t4_wr_done", wr_done, 1);
    step();

    // Test 5: reset in the middle of a write burst
    wr_req = 1'b1;
    wr_addr = 22'h0ABCDE;
    step();
    wr_req = 1'b0;
    step();
    repeat (7) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t5_busy", busy, 0);
    chk("t5_valid", mem_cmd_valid, 0);
    chk("t5_owner", owner, 0);
    chk("t5_cmd", {mem_cmd_we, mem_cmd_addr}, 0);
    chk("t5_pulses", {rd_gnt, wr_gnt, rd_done, wr_done}, 0);
    seen = 1'b0;
    repeat (20) begin
      step();
      if (wr_done || busy) seen = 1'b1;
    end
    chk("t5_no_late_done", seen, 0);
    rd_req = 1'b1;
    rd_addr = 22'h000200;
    step();
    rd_req = 1'b0;
    chk("t5_rd_gnt", rd_gnt, 1);
    chk("t5_rd_addr", mem_cmd_addr, 22'h000200);
    wait_done(n);
    chk("t5_rd_len", n, 17);
    chk("t5_rd_done", rd_done, 1);
    step();

    // Test 6: stray beats in IDLE and ISSUE, sparse beats in BURST
    mem_beat = 1'b1;
    repeat (3) step();
    mem_cmd_ready = 1'b0;
    rd_req = 1'b1;
    rd_addr = 22'h000300;
    step();
    rd_req = 1'b0;
    chk("t6_rd_gnt", rd_gnt, 1);
    repeat (3) step();
    mem_cmd_ready = 1'b1;
    step();
    cnt = 0;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      pat = ((i % 3) != 2);
      mem_beat = pat;
      step();
      if (pat) cnt++;
      if (rd_done) seen = 1'b1;
    end
    mem_beat = 1'b1;
    chk("t6_done_seen", seen, 1);
    chk("t6_beats", cnt, 16);
    step();
    chk("t6_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
